// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings and the DMA master state type.
`timescale 1ns/1ps
package ahblite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_D,
        ST_WR_A,
        ST_WR_D,
        ST_FIN,
        ST_ERR
    } dma_state_t;

endpackage

// File: rtl/ahblite_dma_master.sv
// AHB-Lite word-copy DMA master: one NONSEQ read then one NONSEQ write
// per word, controlled by a start/busy/done sideband.
`timescale 1ns/1ps
module ahblite_dma_master
    import ahblite_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_left,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [2:0]       HBURST,
    output logic [3:0]       HPROT,
    output logic             HMASTLOCK,
    output logic [31:0]      HWDATA,
    input  logic [31:0]      HRDATA,
    input  logic             HREADY,
    input  logic             HRESP
);

    dma_state_t       state;
    dma_state_t       state_nx;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [31:0]      buf_q;
    logic [31:0]      haddr_q;
    logic             hwrite_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             xfer_ok;
    logic             accept;

    assign HSIZE     = HSIZE_WORD;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DATA;
    assign HMASTLOCK = 1'b0;

    assign xfer_ok = HREADY && !HRESP;
    assign accept  = (state == ST_IDLE) && start;

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = (word_count == '0) ? ST_FIN : ST_RD_A;
                end
            end
            ST_RD_A: begin
                if (HREADY) state_nx = ST_RD_D;
            end
            ST_RD_D: begin
                if (HREADY) state_nx = HRESP ? ST_ERR : ST_WR_A;
            end
            ST_WR_A: begin
                if (HREADY) state_nx = ST_WR_D;
            end
            ST_WR_D: begin
                if (HREADY) begin
                    if (HRESP) begin
                        state_nx = ST_ERR;
                    end else if (cnt_q == CNT_W'(1)) begin
                        state_nx = ST_FIN;
                    end else begin
                        state_nx = ST_RD_A;
                    end
                end
            end
            ST_FIN:  state_nx = ST_IDLE;
            ST_ERR:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Outside an address phase the bus keeps showing the last address/direction.
    always_comb begin
        HTRANS = HTRANS_IDLE;
        HADDR  = haddr_q;
        HWRITE = hwrite_q;
        unique case (state)
            ST_RD_A: begin
                HTRANS = HTRANS_NONSEQ;
                HADDR  = src_q;
                HWRITE = 1'b0;
            end
            ST_WR_A: begin
                HTRANS = HTRANS_NONSEQ;
                HADDR  = dst_q;
                HWRITE = 1'b1;
            end
            default: begin
                HTRANS = HTRANS_IDLE;
            end
        endcase
    end

    assign busy       = (state == ST_RD_A) || (state == ST_RD_D) ||
                        (state == ST_WR_A) || (state == ST_WR_D);
    assign done       = (state == ST_FIN) || (state == ST_ERR);
    assign error      = err_q;
    assign words_left = cnt_q;
    assign HWDATA     = buf_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            buf_q    <= '0;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            haddr_q  <= HADDR;
            hwrite_q <= HWRITE;
            if (accept) begin
                src_q <= src_addr & ~32'h3;
                dst_q <= dst_addr & ~32'h3;
                cnt_q <= word_count;
                err_q <= 1'b0;
            end
            if (state == ST_RD_D && xfer_ok) begin
                buf_q <= HRDATA;
            end
            if (state == ST_WR_D && xfer_ok) begin
                src_q <= src_q + 32'd4;
                dst_q <= dst_q + 32'd4;
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (state_nx == ST_ERR) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ahblite_dma_master.sv
// Scoreboard bench for ahblite_dma_master with a wait/error-injecting slave.
`timescale 1ns/1ps
module tb_ahblite_dma_master;
    import ahblite_pkg::*;

    localparam int CNT_W = 16;

    logic             HCLK = 1'b0;
    logic             HRESET;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [CNT_W-1:0] word_count;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] words_left;
    logic [31:0]      HADDR;
    logic [1:0]       HTRANS;
    logic             HWRITE;
    logic [2:0]       HSIZE;
    logic [2:0]       HBURST;
    logic [3:0]       HPROT;
    logic             HMASTLOCK;
    logic [31:0]      HWDATA;
    logic [31:0]      HRDATA;
    logic             HREADY;
    logic             HRESP;

    ahblite_dma_master #(.CNT_W(CNT_W)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
        .busy(busy), .done(done), .error(error), .words_left(words_left),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    // ---------------- slave memory model ----------------
    logic [31:0] mem [logic [31:0]];
    int waits[$];
    int err_ph = -1;

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic int wt(input int p);
        if (p < waits.size()) return waits[p];
        return 0;
    endfunction

    logic        dp_valid;
    logic        dp_write;
    logic [31:0] dp_addr;
    int          ph;
    int          wleft;
    int          errc;
    logic        phase_act;

    always_comb begin
        phase_act = (HTRANS == HTRANS_NONSEQ) || dp_valid;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        if (phase_act) begin
            if (wleft > 0) begin
                HREADY = 1'b0;
            end else if (ph == err_ph) begin
                HRESP  = 1'b1;
                HREADY = (errc != 0);
            end
        end
    end

    always @(posedge HCLK) begin
        if (HRESET) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
            ph       <= 0;
            wleft    <= 0;
            errc     <= 0;
            HRDATA   <= '0;
        end else if (start && !busy && !done) begin
            dp_valid <= 1'b0;
            ph       <= 0;
            wleft    <= wt(0);
            errc     <= 0;
        end else if (phase_act && HREADY) begin
            if (dp_valid && dp_write && !HRESP) mem[dp_addr] = HWDATA;
            if (HTRANS == HTRANS_NONSEQ) begin
                dp_valid <= 1'b1;
                dp_write <= HWRITE;
                dp_addr  <= HADDR;
                if (!HWRITE) HRDATA <= rd_mem(HADDR);
            end else begin
                dp_valid <= 1'b0;
            end
            ph    <= ph + 1;
            wleft <= wt(ph + 1);
            errc  <= 0;
        end else if (phase_act) begin
            if (wleft > 0) wleft <= wleft - 1;
            else errc <= errc + 1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;
    typedef struct {
        int   cycles;
        logic err;
        int   left;
    } cmp_t;

    txn_t exp_q[$];
    cmp_t done_q[$];
    int   checks = 0;
    int   failures = 0;
    int   jobs_done = 0;
    int   t0 = 0;
    logic prev_wait = 1'b0;
    logic prev_wr = 1'b0;
    logic [31:0] prev_addr = '0;
    logic mon_wr = 1'b0;
    logic [31:0] pend = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%0h required=none t=%0t", name, act, $time);
    endtask

    task automatic monitor();
        txn_t e;
        cmp_t c;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                prev_wait = 1'b0;
                mon_wr = 1'b0;
            end else begin
                if (prev_wait) begin
                    chk("addr_hold", {29'd0, HTRANS, HWRITE, HADDR},
                        {29'd0, HTRANS_NONSEQ, prev_wr, prev_addr});
                end
                prev_wait = (HTRANS == HTRANS_NONSEQ) && !HREADY;
                prev_addr = HADDR;
                prev_wr   = HWRITE;
                if (HRESP && !HREADY) chk("htrans_in_err", 64'(HTRANS), 64'(HTRANS_IDLE));
                if (mon_wr && HREADY) begin
                    if (!HRESP) chk("hwdata", 64'(HWDATA), 64'(pend));
                    mon_wr = 1'b0;
                end
                if (HTRANS == HTRANS_NONSEQ && HREADY) begin
                    if (exp_q.size() == 0) begin
                        fail_now("extra_nonseq", {31'd0, HWRITE, HADDR});
                    end else begin
                        e = exp_q.pop_front();
                        chk("txn_addr", {31'd0, HWRITE, HADDR}, {31'd0, e.wr, e.addr});
                        if (HWRITE) begin
                            mon_wr = 1'b1;
                            pend = e.data;
                        end
                    end
                end
                if (done) begin
                    if (done_q.size() == 0) begin
                        fail_now("unexpected_done", 64'(cyc));
                    end else begin
                        c = done_q.pop_front();
                        chk("done_cycle", 64'(cyc - t0), 64'(c.cycles));
                        chk("error", 64'(error), 64'(c.err));
                        chk("words_left", 64'(words_left), 64'(c.left));
                        chk("busy_at_done", 64'(busy), 64'd0);
                        chk("txns_left", 64'(exp_q.size()), 64'd0);
                        jobs_done++;
                    end
                end
            end
        end
    endtask

    // Reference: expected transfers and completion from the job description.
    task automatic push_job(input logic [31:0] s, input logic [31:0] d,
                            input int n, input int ep);
        txn_t t;
        cmp_t c;
        int nw;
        int last;
        nw = (ep < 0) ? n : ep / 4 + 1;
        for (int j = 0; j < nw; j++) begin
            t.wr = 1'b0;
            t.addr = s + 32'(4 * j);
            t.data = '0;
            exp_q.push_back(t);
            if (ep < 0 || j < ep / 4 || ep % 4 == 3) begin
                t.wr = 1'b1;
                t.addr = d + 32'(4 * j);
                t.data = rd_mem(s + 32'(4 * j));
                exp_q.push_back(t);
            end
        end
        c.cycles = 1;
        if (n > 0) begin
            last = (ep < 0) ? 4 * n - 1 : ep;
            for (int p = 0; p <= last; p++) begin
                c.cycles += (p == ep) ? 2 + wt(p) : 1 + wt(p);
            end
        end
        c.err = (ep >= 0);
        c.left = (ep < 0) ? 0 : n - ep / 4;
        done_q.push_back(c);
    endtask

    task automatic wait_idle();
        int lim;
        lim = 0;
        while ((busy || done) && lim < 3000) begin
            @(negedge HCLK);
            lim++;
        end
        if (lim >= 3000) fail_now("idle_timeout", 64'(cyc));
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input int n);
        src_addr = s;
        dst_addr = d;
        word_count = CNT_W'(n);
        start = 1'b1;
        t0 = cyc;
        @(negedge HCLK);
        start = 1'b0;
        chk("busy_cycle1", 64'(busy), 64'(n != 0));
        chk("error_cleared", 64'(error), 64'd0);
    endtask

    task automatic run_job(input logic [31:0] s, input logic [31:0] d,
                           input int n, input int ep, input bit poke);
        int target;
        int lim;
        wait_idle();
        target = jobs_done + 1;
        push_job(s & ~32'h3, d & ~32'h3, n, ep);
        do_start(s, d, n);
        if (poke) begin
            repeat (2) @(negedge HCLK);
            src_addr = 32'h7777_0000;
            dst_addr = 32'h7777_1000;
            word_count = CNT_W'(5);
            start = 1'b1;
            @(negedge HCLK);
            start = 1'b0;
        end
        lim = 0;
        while (jobs_done < target && lim < 3000) begin
            @(negedge HCLK);
            lim++;
        end
        if (jobs_done < target) begin
            fail_now("job_timeout", 64'(cyc));
            exp_q.delete();
            done_q.delete();
        end
    endtask

    task automatic zero_plan();
        waits.delete();
        err_ph = -1;
    endtask

    initial begin
        int nw;
        int n;
        int ep;
        logic [31:0] s;
        logic [31:0] d;
        txn_t t;
        HRESET = 1'b1;
        start = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        word_count = '0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge HCLK);
        chk("rst_htrans", 64'(HTRANS), 64'(HTRANS_IDLE));
        chk("rst_haddr", 64'(HADDR), 64'd0);
        chk("rst_hwrite_hwdata", {31'd0, HWRITE, HWDATA}, 64'd0);
        chk("rst_flags", {61'd0, busy, done, error}, 64'd0);
        chk("rst_words_left", 64'(words_left), 64'd0);
        chk("const_outs", {53'd0, HSIZE, HBURST, HPROT, HMASTLOCK},
            {53'd0, 3'b010, 3'b000, 4'b0011, 1'b0});
        HRESET = 1'b0;
        @(negedge HCLK);

        zero_plan();
        run_job(32'h2000_0000, 32'h2000_0100, 3, -1, 1'b0);
        for (int j = 0; j < 3; j++) begin
            chk("dst_mem", 64'(rd_mem(32'h2000_0100 + 32'(4 * j))),
                64'(rd_mem(32'h2000_0000 + 32'(4 * j))));
        end

        zero_plan();
        waits = '{2, 0, 0, 0};
        run_job(32'h2100_0040, 32'h2100_0800, 1, -1, 1'b0);

        zero_plan();
        err_ph = 7;
        run_job(32'h2200_0000, 32'h2200_1000, 3, 7, 1'b0);
        wait_idle();
        @(negedge HCLK);
        chk("error_sticky", 64'(error), 64'd1);
        zero_plan();
        run_job(32'h2300_0000, 32'h2300_1000, 1, -1, 1'b0);

        zero_plan();
        run_job(32'h2400_0000, 32'h2400_1000, 0, -1, 1'b0);

        zero_plan();
        run_job(32'hFFFF_FFFC, 32'h3000_0000, 2, -1, 1'b0);

        zero_plan();
        run_job(32'h2500_0003, 32'h2500_1002, 3, -1, 1'b1);

        // Reset asserted during the address phase of the second write.
        zero_plan();
        wait_idle();
        s = 32'h5000_0000;
        d = 32'h6000_0000;
        for (int j = 0; j < 2; j++) begin
            t.wr = 1'b0; t.addr = s + 32'(4 * j); t.data = '0;
            exp_q.push_back(t);
            t.wr = 1'b1; t.addr = d + 32'(4 * j); t.data = rd_mem(s + 32'(4 * j));
            exp_q.push_back(t);
        end
        do_start(s, d, 3);
        nw = 0;
        for (int k = 0; k < 40 && nw < 2; k++) begin
            if (HTRANS == HTRANS_NONSEQ && HWRITE) nw++;
            if (nw < 2) @(negedge HCLK);
        end
        chk("reached_wr_a1", 64'(nw), 64'd2);
        HRESET = 1'b1;
        @(negedge HCLK);
        chk("mid_rst_htrans", 64'(HTRANS), 64'(HTRANS_IDLE));
        chk("mid_rst_flags", {61'd0, busy, done, error}, 64'd0);
        chk("mid_rst_outs", {31'd0, HWRITE, HADDR}, 64'd0);
        chk("mid_rst_data", {16'd0, words_left, HWDATA}, 64'd0);
        HRESET = 1'b0;
        exp_q.delete();
        done_q.delete();
        mon_wr = 1'b0;
        prev_wait = 1'b0;
        repeat (10) @(negedge HCLK);

        for (int r = 0; r < 24; r++) begin
            n = $urandom_range(0, 6);
            waits.delete();
            for (int p = 0; p < 4 * n; p++) begin
                waits.push_back(($urandom % 10 < 3) ? $urandom_range(1, 2) : 0);
            end
            ep = -1;
            if (n > 0 && $urandom % 5 == 0) ep = 2 * $urandom_range(0, 2 * n - 1) + 1;
            err_ph = ep;
            s = 32'h1000_0000 | ($urandom & 32'h0000_FFFF);
            d = 32'h4000_0000 | ($urandom & 32'h0000_FFFF);
            run_job(s, d, n, ep, 1'b0);
        end

        wait_idle();
        repeat (3) @(negedge HCLK);
        chk("final_queues", 64'(exp_q.size() + done_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
